// File: rtl/gbx_pkg.sv
// gbx_pkg: shared definitions for the gearbox read-side controller.
//   gbx_state_e : controller state encoding (FILL, DRAIN, HOLD)
//   gbx_idx_w() : bits needed to index/count n items (minimum 1)
package gbx_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } gbx_state_e;

  function automatic int unsigned gbx_idx_w(input int unsigned n);
    int unsigned w;
    if (n <= 1) w = 1;
    else        w = $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/gbx_rd_ctrl.sv
// gbx_rd_ctrl: packs RATIO consecutive DW-bit words from an async FIFO read
// port into one wide output beat, with flush support for partial beats.
// Ports:
//   rd_clk, rd_rst_n  : read-domain clock, async active-low reset
//   fifo_empty        : FIFO empty flag (rd_clk domain)
//   fifo_rd_en        : FIFO read strobe (combinational, gated by reset)
//   fifo_rd_data      : FIFO read data, valid one cycle after fifo_rd_en
//   flush             : single-cycle request to emit a partial beat
//   out_data/out_keep : packed beat (lane 0 = oldest word) and lane mask
//   out_valid/out_ready : beat handshake
//   beat_cnt          : number of accepted beats, wraps
module gbx_rd_ctrl
  import gbx_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned RATIO = 4,   // legal range 2..16
  parameter int unsigned CW    = 16
) (
  input  logic                rd_clk,
  input  logic                rd_rst_n,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  input  logic [DW-1:0]       fifo_rd_data,
  input  logic                flush,
  output logic [DW*RATIO-1:0] out_data,
  output logic [RATIO-1:0]    out_keep,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       beat_cnt
);

  localparam int unsigned BW   = DW * RATIO;
  localparam int unsigned FCW  = gbx_idx_w(RATIO + 1);  // fill count holds 0..RATIO
  localparam int unsigned FCW1 = FCW + 1;

  gbx_state_e       r_state, w_state_nxt;
  logic [FCW-1:0]   r_fill_cnt, w_fill_nxt;
  logic             r_pend;
  logic [BW-1:0]    r_data, w_data_nxt;
  logic [RATIO-1:0] r_keep, w_keep_nxt;
  logic             r_valid, w_valid_nxt;
  logic [CW-1:0]    r_beat_cnt, w_beat_nxt;

  logic [FCW1-1:0]  w_inflight;
  logic             w_flush_seen;
  logic             w_rd_en;
  logic             w_last;
  logic             w_close;

  // State and datapath registers.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_state    <= FILL;
      r_fill_cnt <= '0;
      r_pend     <= 1'b0;
      r_data     <= '0;
      r_keep     <= '0;
      r_valid    <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_pend     <= fifo_rd_en;
      r_data     <= w_data_nxt;
      r_keep     <= w_keep_nxt;
      r_valid    <= w_valid_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end

  // Next-state, lane capture and read-strobe logic.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill_cnt;
    w_data_nxt  = r_data;
    w_keep_nxt  = r_keep;
    w_valid_nxt = r_valid;
    w_beat_nxt  = r_beat_cnt;
    w_close     = 1'b0;

    // Words captured plus the one still in flight.
    w_inflight   = {1'b0, r_fill_cnt} + FCW1'(r_pend);
    // A flush with nothing collected is ignored, so it must not stall reads.
    w_flush_seen = flush && (r_state == FILL) && (w_inflight != '0);
    w_rd_en      = (r_state == FILL) && !fifo_empty &&
                   (w_inflight < FCW1'(RATIO)) && !w_flush_seen;
    w_last       = r_pend && (r_fill_cnt == FCW'(RATIO - 1));

    // The in-flight word always lands in the next free lane.
    if (r_pend) begin
      for (int k = 0; k < RATIO; k++) begin
        if (r_fill_cnt == FCW'(k)) w_data_nxt[k*DW +: DW] = fifo_rd_data;
      end
      w_fill_nxt = r_fill_cnt + FCW'(1);
    end

    case (r_state)
      FILL: begin
        // A full beat takes priority and absorbs a coincident flush.
        if (w_last) begin
          w_state_nxt = HOLD;
          w_close     = 1'b1;
        end else if (w_flush_seen) begin
          if (r_pend) begin
            w_state_nxt = DRAIN;
          end else begin
            w_state_nxt = HOLD;
            w_close     = 1'b1;
          end
        end
      end
      DRAIN: begin
        w_state_nxt = HOLD;
        w_close     = 1'b1;
      end
      HOLD: begin
        if (r_valid && out_ready) begin
          w_state_nxt = FILL;
          w_valid_nxt = 1'b0;
          w_keep_nxt  = '0;
          w_fill_nxt  = '0;
          w_data_nxt  = '0;  // unused lanes of the next partial beat read as zero
          w_beat_nxt  = r_beat_cnt + CW'(1);
        end
      end
      default: w_state_nxt = FILL;
    endcase

    // Beat becomes visible: mask covers every lane filled so far.
    if (w_close) begin
      w_valid_nxt = 1'b1;
      for (int k = 0; k < RATIO; k++) begin
        w_keep_nxt[k] = (FCW'(k) < w_fill_nxt);
      end
    end
  end

  assign fifo_rd_en = w_rd_en && rd_rst_n;
  assign out_data   = r_data;
  assign out_keep   = r_keep;
  assign out_valid  = r_valid;
  assign beat_cnt   = r_beat_cnt;

endmodule

// File: tb/tb_gbx_rd_ctrl.sv
// tb_gbx_rd_ctrl: self-checking bench for gbx_rd_ctrl (DW=8, RATIO=4).
// A behavioural FIFO feeds the DUT; expected beats are queued when words
// are pushed and compared when the DUT hands a beat over.
module tb_gbx_rd_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned BW    = DW * RATIO;

  logic             rd_clk = 1'b0;
  logic             rd_rst_n;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [DW-1:0]    fifo_rd_data;
  logic             flush;
  logic [BW-1:0]    out_data;
  logic [RATIO-1:0] out_keep;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    beat_cnt;

  gbx_rd_ctrl #(.DW(DW), .RATIO(RATIO), .CW(CW)) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .flush        (flush),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .beat_cnt     (beat_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct packed {
    logic [BW-1:0]    data;
    logic [RATIO-1:0] keep;
  } beat_t;

  // Words listed in push order (first word in the top byte) and the beat expected.
  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] exp;
  } vec_t;

  beat_t         exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int            total = 0;
  int            bad   = 0;
  int            n_acc = 0;
  bit            tog_mode = 1'b0;
  bit            tog_ph   = 1'b0;
  bit            s_rd;
  bit            s_valid;
  bit            prev_hold = 1'b0;
  logic [BW-1:0]    prev_data;
  logic [RATIO-1:0] prev_keep;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic upd_empty();
    fifo_empty = (fifo_q.size() == 0) || (tog_mode && tog_ph);
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    upd_empty();
  endtask

  task automatic expect_beat(input logic [BW-1:0] d, input logic [RATIO-1:0] k);
    beat_t b;
    b.data = d;
    b.keep = k;
    exp_q.push_back(b);
  endtask

  // One clock: sample and check at negedge, then model the FIFO after the edge.
  task automatic tick();
    beat_t e;
    @(negedge rd_clk);
    s_rd    = fifo_rd_en;
    s_valid = out_valid;
    if (fifo_empty) chk("empty_guard_rd_en", 64'(fifo_rd_en), 64'h0);
    if (out_valid)  chk("no_read_in_hold", 64'(fifo_rd_en), 64'h0);
    if (prev_hold && rd_rst_n) begin
      chk("hold_data_stable", 64'(out_data), 64'(prev_data));
      chk("hold_keep_stable", 64'(out_keep), 64'(prev_keep));
      chk("hold_valid_stable", 64'(out_valid), 64'h1);
    end
    if (out_valid && out_ready && rd_rst_n) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat: got data=%0h keep=%0h want=none", out_data, out_keep);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 64'(out_data), 64'(e.data));
        chk("beat_keep", 64'(out_keep), 64'(e.keep));
      end
      chk("beat_cnt_at_accept", 64'(beat_cnt), 64'(CW'(n_acc)));
      n_acc++;
    end
    prev_hold = out_valid && !out_ready && rd_rst_n;
    prev_data = out_data;
    prev_keep = out_keep;
    @(posedge rd_clk);
    #1;
    if (s_rd && rd_rst_n && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
    else                                         fifo_rd_data = DW'($urandom);
    tog_ph = !tog_ph;
    upd_empty();
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n;
    n = 0;
    while (n_acc < target && n < budget) begin
      tick();
      n++;
    end
    chk("beats_by_deadline", 64'(n_acc), 64'(target));
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    chk("valid_by_deadline", 64'(out_valid), 64'h1);
  endtask

  task automatic wait_reads(input int nreads, input int budget);
    int nrd;
    int n;
    nrd = 0;
    n   = 0;
    while (nrd < nreads && n < budget) begin
      tick();
      if (s_rd) nrd++;
      n++;
    end
    chk("read_count", 64'(nrd), 64'(nreads));
  endtask

  initial begin
    vec_t  vecs[5];
    int    first_rd;
    int    first_v;
    int    base;
    logic [31:0] s;

    vecs[0] = '{seq: 32'hDEADBEEF, exp: 32'hEFBEADDE};
    vecs[1] = '{seq: 32'h00FF00FF, exp: 32'hFF00FF00};
    vecs[2] = '{seq: 32'hA5A5A55A, exp: 32'h5AA5A5A5};
    vecs[3] = '{seq: 32'h01020304, exp: 32'h04030201};
    vecs[4] = '{seq: 32'h80000001, exp: 32'h01000080};

    rd_rst_n     = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    fifo_rd_data = '0;
    fifo_empty   = 1'b1;
    repeat (2) @(posedge rd_clk);
    #1;

    // Reset: words available but read strobe must stay gated.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    expect_beat(32'h44332211, 4'hF);
    tick();
    chk("rst_rd_en", 64'(s_rd), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_keep", 64'(out_keep), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'h0);

    // Steady stream and first-beat latency.
    rd_rst_n = 1'b1;
    first_rd = -1;
    first_v  = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_rd && first_rd < 0) first_rd = i;
      if (s_valid && first_v < 0) first_v = i;
      if (first_v >= 0) break;
    end
    chk("first_read_cycle", 64'(first_rd), 64'h0);
    chk("beat_latency", 64'(first_v - first_rd), 64'(RATIO + 1));
    out_ready = 1'b1;
    wait_beats(1, 10);
    tick();
    chk("beat_cnt_after_first", 64'(beat_cnt), 64'h1);

    // Table-driven back-to-back full beats.
    base = n_acc;
    for (int v = 0; v < 5; v++) begin
      s = vecs[v].seq;
      for (int i = 0; i < 4; i++) push(s[31-8*i -: 8]);
      expect_beat(vecs[v].exp, 4'hF);
    end
    wait_beats(base + 5, 40);
    tick();
    chk("beat_cnt_after_table", 64'(beat_cnt), 64'(base + 5));

    // Backpressure: 8 words queued, consumer stalls 10 cycles; flush in HOLD ignored.
    out_ready = 1'b0;
    base = n_acc;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    expect_beat(32'h04030201, 4'hF);
    expect_beat(32'h08070605, 4'hF);
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      flush = (i == 4);
      tick();
      chk("bp_no_read", 64'(s_rd), 64'h0);
      chk("bp_data", 64'(out_data), 64'h04030201);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    wait_beats(base + 2, 20);

    // Partial flush after two captured words.
    out_ready = 1'b0;
    base = n_acc;
    push(8'hA1); push(8'hB2);
    expect_beat(32'h0000B2A1, 4'h3);
    repeat (5) tick();
    chk("pf_no_early_valid", 64'(out_valid), 64'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pf_valid", 64'(out_valid), 64'h1);
    chk("pf_keep", 64'(out_keep), 64'h3);
    chk("pf_data", 64'(out_data), 64'h0000B2A1);
    out_ready = 1'b1;
    wait_beats(base + 1, 5);

    // Flush with nothing collected is ignored.
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    chk("idle_flush_ignored", 64'(out_valid), 64'h0);

    // Flush one cycle after the 3rd read: one DRAIN cycle, 3-lane beat.
    out_ready = 1'b0;
    base = n_acc;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    expect_beat(32'h00C3C2C1, 4'h7);
    wait_reads(3, 20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_rd_blocked", 64'(s_rd), 64'h0);
    chk("drain_not_valid", 64'(out_valid), 64'h0);
    tick();
    chk("drain_no_read", 64'(s_rd), 64'h0);
    chk("drain_valid", 64'(out_valid), 64'h1);
    chk("drain_keep", 64'(out_keep), 64'h7);
    chk("drain_data", 64'(out_data), 64'h00C3C2C1);
    push(8'hD1); push(8'hD2); push(8'hD3);
    expect_beat(32'hD3D2D1C4, 4'hF);
    out_ready = 1'b1;
    wait_beats(base + 2, 20);

    // Flush coinciding with the 4th capture: full beat, flush consumed.
    out_ready = 1'b0;
    base = n_acc;
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    expect_beat(32'h54535251, 4'hF);
    wait_reads(4, 20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("coinc_valid", 64'(out_valid), 64'h1);
    chk("coinc_keep", 64'(out_keep), 64'hF);
    out_ready = 1'b1;
    wait_beats(base + 1, 5);
    repeat (4) tick();
    chk("coinc_no_extra_beat", 64'(out_valid), 64'h0);

    // Empty flag toggling every cycle: no read on empty, order preserved.
    tog_mode = 1'b1;
    base = n_acc;
    for (int i = 0; i < 8; i++) push(DW'(8'h60 + i));
    expect_beat(32'h63626160, 4'hF);
    expect_beat(32'h67666564, 4'hF);
    wait_beats(base + 2, 60);
    tog_mode = 1'b0;
    upd_empty();

    // Reset mid-beat: partial lanes discarded, next beat is post-reset words only.
    out_ready = 1'b0;
    push(8'hF1); push(8'hF2);
    repeat (4) tick();
    rd_rst_n = 1'b0;
    #1;
    chk("midrst_data", 64'(out_data), 64'h0);
    chk("midrst_keep", 64'(out_keep), 64'h0);
    chk("midrst_valid", 64'(out_valid), 64'h0);
    chk("midrst_beat_cnt", 64'(beat_cnt), 64'h0);
    n_acc = 0;
    prev_hold = 1'b0;
    push(8'h71); push(8'h72); push(8'h73); push(8'h74);
    chk("midrst_rd_gated", 64'(fifo_rd_en), 64'h0);
    expect_beat(32'h74737271, 4'hF);
    tick();
    tick();
    rd_rst_n = 1'b1;
    out_ready = 1'b1;
    wait_beats(1, 15);
    tick();
    chk("midrst_beat_cnt_after", 64'(beat_cnt), 64'h1);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gbx_rd_ctrl.md
GBX_RD_CTRL -- requirements
Module: gbx_rd_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8: FIFO word width in bits.
REQ-002 SHALL have parameter RATIO, default 4: FIFO words per output beat, range 2..16.
REQ-003 SHALL have parameter CW, default 16: beat counter width.
REQ-004 SHALL have rd_clk  input  1  read-domain clock; all logic rises on it.
REQ-005 SHALL have rd_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have fifo_empty  input  1  async FIFO empty flag, rd_clk domain.
REQ-007 SHALL have fifo_rd_en  output  1  FIFO read strobe.
REQ-008 SHALL have fifo_rd_data  input  DW  FIFO read data, valid exactly 1 cycle after fifo_rd_en.
REQ-009 SHALL have flush  input  1  single-cycle request to emit a partial beat.
REQ-010 SHALL have out_data  output  DW*RATIO  packed beat; lane k = bits [k*DW +: DW].
REQ-011 SHALL have out_keep  output  RATIO  lane-valid mask.
REQ-012 SHALL have out_valid  output  1  beat available.
REQ-013 SHALL have out_ready  input  1  consumer accepts beat.
REQ-014 SHALL have beat_cnt  output  CW  accepted beats, wraps modulo 2^CW.

Function
REQ-015 SHALL implement states FILL, DRAIN (flush waiting on in-flight read), HOLD.
REQ-016 SHALL drive fifo_rd_en = (state==FILL) && !fifo_empty && (fill_cnt + pend) < RATIO && !flush_seen, combinationally.
REQ-017 SHALL never assert fifo_rd_en while fifo_empty=1; the FIFO does not guard reads on empty.
REQ-018 SHALL register pend = fifo_rd_en, and capture fifo_rd_data into lane fill_cnt when pend=1, then increment fill_cnt.
REQ-019 SHALL fill lanes LSB-first; lane 0 holds the oldest word.
REQ-020 SHALL move FILL->HOLD in the cycle the RATIO-th word is captured, with out_valid=1 and out_keep all-ones from the next cycle.
REQ-021 SHALL, on flush in FILL with fill_cnt+pend=0, ignore the flush with no state change.
REQ-022 SHALL, on flush in FILL with pend=0 and fill_cnt>0, move to HOLD with out_keep = (1<<fill_cnt)-1.
REQ-023 SHALL, on flush in FILL with pend=1, move to DRAIN, capture the pending word, then move to HOLD with the partial mask.
REQ-024 SHALL, when flush coincides with capture of the RATIO-th word, emit a full beat and consume the flush.
REQ-025 SHALL zero unused lanes of out_data for partial beats.
REQ-026 SHALL hold out_data, out_keep and out_valid stable in HOLD until out_valid && out_ready.
REQ-027 SHALL, on accept, clear out_valid, out_keep and fill_cnt, increment beat_cnt, and return to FILL the next cycle.
REQ-028 SHALL issue no FIFO reads in DRAIN or HOLD, and SHALL ignore flush in those states.
REQ-029 SHALL sustain 1 word per cycle in FILL while fifo_empty=0; beat latency = RATIO+1 cycles from the first fifo_rd_en to out_valid.

Reset
REQ-030 SHALL, while rd_rst_n=0, force state=FILL, fill_cnt=0, pend=0, out_data=0, out_keep=0, out_valid=0, beat_cnt=0, and fifo_rd_en=0 (gated).
REQ-031 SHALL discard partially filled lanes on reset mid-beat; no beat is emitted for them.
REQ-032 SHALL not advance the FIFO in the first cycle after reset deassertion unless fifo_empty=0.

Structure
REQ-033 SHALL place the state encoding (FILL=2'd0, DRAIN=2'd1, HOLD=2'd2) and the lane-index width function in shared package gbx_pkg.
REQ-034 SHALL be a single module with no sub-modules; the FIFO is instantiated by the parent.

Verification
REQ-035 SHALL cover steady stream: FIFO holds 0x11,0x22,0x33,0x44, out_ready=1 -> out_data=0x44332211, out_keep=4'hF, beat_cnt=1.
REQ-036 SHALL cover backpressure: out_ready=0 for 10 cycles with 8 words queued -> fifo_rd_en=0 in HOLD, out_data stable; second beat follows accept.
REQ-037 SHALL cover partial flush: 0xA1,0xB2 captured, flush -> out_data=0x0000B2A1, out_keep=4'h3.
REQ-038 SHALL cover flush during in-flight read: flush in the cycle after the 3rd fifo_rd_en -> DRAIN 1 cycle, out_keep=4'h7.
REQ-039 SHALL cover empty guard: fifo_empty toggling every cycle -> fifo_rd_en never 1 with empty=1; word order preserved.
REQ-040 SHALL cover reset mid-beat: rd_rst_n low after 2 captures -> all outputs 0; next beat contains only post-reset words.
